// File: rtl/key_event_conditioner.sv
`default_nettype none
// key_event_conditioner: three-key debouncer with press/release/short/long events.
// Rev 1.0 - initial release.
module key_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_key_n,
    output logic [2:0] o_down,
    output logic [2:0] o_press,
    output logic [2:0] o_release,
    output logic [2:0] o_short,
    output logic [2:0] o_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [2:0] sync1, sync2;
    logic [2:0] down_q, press_q, release_q, short_q, long_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= i_key_n;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_key
        state_t        state, state_nx;
        logic [DW-1:0] dcnt, dcnt_nx;
        logic [HW-1:0] hcnt, hcnt_nx;
        logic          long_flag, long_flag_nx;
        logic          ev_press, ev_release, ev_short, ev_long, hold_hit;
        logic          evq_press, evq_release, evq_short, evq_long, evq_down;
        logic          s;

        assign s = sync2[k];

        always_comb begin
            state_nx     = state;
            dcnt_nx      = dcnt;
            hcnt_nx      = hcnt;
            long_flag_nx = long_flag;
            ev_press     = 1'b0;
            ev_release   = 1'b0;
            ev_short     = 1'b0;
            ev_long      = 1'b0;
            hold_hit     = 1'b0;
            if ((state == HELD) || (state == REL_CHK)) begin
                if (hcnt != HOLD_MAX) hcnt_nx = hcnt + 1'b1;
                hold_hit = (hcnt == HOLD_HIT) && !long_flag;
            end
            case (state)
                IDLE: if (!s) begin
                    state_nx = PRESS_CHK;
                    dcnt_nx  = DW'(1);
                end
                PRESS_CHK: if (s) begin
                    state_nx = IDLE;
                    dcnt_nx  = '0;
                end else if (dcnt == DEB_MAX) begin
                    state_nx     = HELD;
                    dcnt_nx      = '0;
                    hcnt_nx      = '0;
                    long_flag_nx = 1'b0;
                    ev_press     = 1'b1;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
                HELD: if (s) begin
                    state_nx = REL_CHK;
                    dcnt_nx  = DW'(1);
                end
                REL_CHK: if (!s) begin
                    state_nx = HELD;
                    dcnt_nx  = '0;
                end else if (dcnt == DEB_MAX) begin
                    state_nx     = IDLE;
                    dcnt_nx      = '0;
                    hcnt_nx      = '0;
                    long_flag_nx = 1'b0;
                    ev_release   = 1'b1;
                    ev_short     = !long_flag;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
                default: state_nx = IDLE;
            endcase
            // A release confirmed on the same edge the hold completes wins: no long.
            if (hold_hit && !ev_release) begin
                ev_long      = 1'b1;
                long_flag_nx = 1'b1;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state       <= IDLE;
                dcnt        <= '0;
                hcnt        <= '0;
                long_flag   <= 1'b0;
                evq_press   <= 1'b0;
                evq_release <= 1'b0;
                evq_short   <= 1'b0;
                evq_long    <= 1'b0;
                evq_down    <= 1'b0;
            end else begin
                state       <= state_nx;
                dcnt        <= dcnt_nx;
                hcnt        <= hcnt_nx;
                long_flag   <= long_flag_nx;
                evq_press   <= ev_press;
                evq_release <= ev_release;
                evq_short   <= ev_short;
                evq_long    <= ev_long;
                evq_down    <= (state_nx == HELD) || (state_nx == REL_CHK);
            end
        end

        assign press_q[k]   = evq_press;
        assign release_q[k] = evq_release;
        assign short_q[k]   = evq_short;
        assign long_q[k]    = evq_long;
        assign down_q[k]    = evq_down;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_down    <= '0;
            o_press   <= '0;
            o_release <= '0;
            o_short   <= '0;
            o_long    <= '0;
        end else begin
            o_down    <= down_q;
            o_press   <= press_q;
            o_release <= release_q;
            o_short   <= short_q;
            o_long    <= long_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_key_event_conditioner.sv
`default_nettype none
// tb_key_event_conditioner: scoreboard bench with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_key_event_conditioner;
    localparam int DEB = 4;
    localparam int LNG = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic [2:0] down, press, rel, shrt, lng;
    logic [11:0] cur;

    key_event_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n),
        .o_down(down), .o_press(press), .o_release(rel),
        .o_short(shrt), .o_long(lng)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    assign cur = {lng, shrt, rel, press};

    typedef struct {
        int          cyc;
        logic [11:0] ev;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic expect_ev(input int cyc, input logic [2:0] p, input logic [2:0] r,
                             input logic [2:0] s, input logic [2:0] l);
        exp_t e;
        e.cyc = cyc;
        e.ev  = {l, s, r, p};
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        wait_neg(12);
        check(exp_q.size() == 0, name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every visible pulse must match the next expected event, cycle included.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (cur != 12'd0)) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_event", {edge_n[19:0], cur}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check((e.cyc == edge_n) && (e.ev == cur), "event",
                      {edge_n[19:0], cur}, {e.cyc[19:0], e.ev});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0, t1;
        wait_neg(3);
        check({down, cur} == 15'd0, "reset_outputs", {17'd0, down, cur}, 32'd0);
        rst_n = 1'b1;
        wait_neg(3);

        // Clean press on key0
        t0 = edge_n + 1;
        key_n[0] = 1'b0;
        expect_ev(t0 + 7, 3'b001, 3'b000, 3'b000, 3'b000);
        expect_ev(t0 + 17, 3'b000, 3'b001, 3'b001, 3'b000);
        wait_neg(7);
        check(down == 3'b000, "t1_down_before_press", 32'(down), 32'd0);
        wait_neg(1);
        check(down == 3'b001, "t1_down_at_press", 32'(down), 32'd1);
        wait_neg(2);
        key_n[0] = 1'b1;
        wait_neg(7);
        check(down == 3'b001, "t1_down_before_release", 32'(down), 32'd1);
        wait_neg(1);
        check(down == 3'b000, "t1_down_at_release", 32'(down), 32'd0);
        drain("t1_events_seen");

        // Bouncing key1 never confirms
        key_n[1] = 1'b0; wait_neg(2);
        key_n[1] = 1'b1; wait_neg(1);
        key_n[1] = 1'b0; wait_neg(2);
        key_n[1] = 1'b1; wait_neg(6);
        check(down == 3'b000, "t2_bounce_down", 32'(down), 32'd0);
        drain("t2_events_seen");

        // Long hold on key2
        t0 = edge_n + 1;
        key_n[2] = 1'b0;
        expect_ev(t0 + 7, 3'b100, 3'b000, 3'b000, 3'b000);
        expect_ev(t0 + 27, 3'b000, 3'b000, 3'b000, 3'b100);
        expect_ev(t0 + 47, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_neg(40);
        check(down == 3'b100, "t3_down_held", 32'(down), 32'd4);
        key_n[2] = 1'b1;
        drain("t3_events_seen");

        // Release bounce on key0, hold time keeps accumulating
        t0 = edge_n + 1;
        key_n[0] = 1'b0;
        expect_ev(t0 + 7, 3'b001, 3'b000, 3'b000, 3'b000);
        expect_ev(t0 + 27, 3'b000, 3'b000, 3'b000, 3'b001);
        expect_ev(t0 + 37, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_neg(10);
        key_n[0] = 1'b1;
        wait_neg(2);
        key_n[0] = 1'b0;
        wait_neg(4);
        check(down == 3'b001, "t4_down_through_bounce", 32'(down), 32'd1);
        wait_neg(14);
        key_n[0] = 1'b1;
        drain("t4_events_seen");

        // Simultaneous press of keys 0 and 1
        t0 = edge_n + 1;
        key_n[1:0] = 2'b00;
        expect_ev(t0 + 7, 3'b011, 3'b000, 3'b000, 3'b000);
        expect_ev(t0 + 17, 3'b000, 3'b011, 3'b011, 3'b000);
        wait_neg(8);
        check(down == 3'b011, "t5_down_both", 32'(down), 32'd3);
        wait_neg(2);
        key_n[1:0] = 2'b11;
        drain("t5_events_seen");

        // Reset mid-hold with key0 still low across deassertion
        t0 = edge_n + 1;
        key_n[0] = 1'b0;
        expect_ev(t0 + 7, 3'b001, 3'b000, 3'b000, 3'b000);
        wait_neg(12);
        check(down == 3'b001, "t6_down_before_reset", 32'(down), 32'd1);
        rst_n = 1'b0;
        #1;
        check({down, cur} == 15'd0, "t6_reset_clears", {17'd0, down, cur}, 32'd0);
        wait_neg(2);
        check({down, cur} == 15'd0, "t6_reset_holds", {17'd0, down, cur}, 32'd0);
        rst_n = 1'b1;
        t1 = edge_n + 1;
        expect_ev(t1 + 7, 3'b001, 3'b000, 3'b000, 3'b000);
        expect_ev(t1 + 17, 3'b000, 3'b001, 3'b001, 3'b000);
        wait_neg(8);
        check(down == 3'b001, "t6_down_after_reset", 32'(down), 32'd1);
        wait_neg(2);
        key_n[0] = 1'b1;
        drain("t6_events_seen");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/key_event_conditioner.md
KEY_EVENT_CONDITIONER -- requirements
Module: key_event_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, which sets the stable-sample count required to confirm a press or a release (10 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, which sets the held-time count after press confirmation that produces a long-press event (1 s at 50 MHz).
REQ-003 SHALL have port i_clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_key_n, input, 3 bits: raw push-buttons, active-low, asynchronous to i_clk; bit k is key k.
REQ-006 SHALL have port o_down, output, 3 bits: debounced level per key, 1 = confirmed held.
REQ-007 SHALL have port o_press, output, 3 bits: one-cycle pulse when a press is confirmed.
REQ-008 SHALL have port o_release, output, 3 bits: one-cycle pulse when a release is confirmed.
REQ-009 SHALL have port o_short, output, 3 bits: one-cycle pulse with o_release when no o_long fired during that press.
REQ-010 SHALL have port o_long, output, 3 bits: one-cycle pulse when the hold reaches LONG_CYCLES.

Function
REQ-011 SHALL pass each i_key_n bit through a 2-flop synchronizer; the second flop output is s_k, and both flops reset to 1 (released).
REQ-012 SHALL run three identical, independent per-key FSMs with states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-013 IDLE: when s_k=0, SHALL go to PRESS_CHK with debounce count = 1.
REQ-014 PRESS_CHK: when s_k=1, SHALL return to IDLE, clear the count and emit no event.
REQ-015 PRESS_CHK: when s_k=0, SHALL increment the count; when the count equals DEBOUNCE_CYCLES, SHALL go to HELD on the next edge.
REQ-016 On entering HELD, SHALL set o_down=1, pulse o_press, and clear the hold count and long flag.
REQ-017 Given stable low input, o_press SHALL assert on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples i_key_n low.
REQ-018 HELD: when s_k=1, SHALL go to REL_CHK with debounce count = 1.
REQ-019 REL_CHK: when s_k=0, SHALL return to HELD with no event, keeping the hold count and long flag.
REQ-020 REL_CHK: when the count equals DEBOUNCE_CYCLES, SHALL go to IDLE, set o_down=0, pulse o_release, and pulse o_short if the long flag is 0.
REQ-021 SHALL increment the hold count every cycle in HELD and REL_CHK, saturating at LONG_CYCLES.
REQ-022 SHALL pulse o_long exactly LONG_CYCLES cycles after o_press, once per press, and set the long flag.
REQ-023 If the release is confirmed before o_long fires, o_long SHALL NOT fire for that press.
REQ-024 o_long and o_release SHALL never both be asserted for the same key in the same cycle.
REQ-025 All outputs SHALL be registered, and every pulse SHALL be exactly one cycle wide.
REQ-026 Keys SHALL be independent; pulses on several bits in the same cycle are legal.
REQ-027 Counter widths SHALL be $clog2(LONG_CYCLES+1) and $clog2(DEBOUNCE_CYCLES+1) bits; no counter SHALL wrap.
REQ-028 The block SHALL require DEBOUNCE_CYCLES >= 1 and LONG_CYCLES >= 1.

Reset
REQ-029 While i_rst_n=0: all FSMs SHALL be in IDLE, all counters 0, all flags 0, synchronizer flops 1, and o_down, o_press, o_release, o_short and o_long all 0.
REQ-030 Reset asserted mid-press SHALL abort immediately with no release, short or long pulse afterwards.
REQ-031 A key held low across reset deassertion SHALL produce o_press after the normal REQ-017 latency.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-032 Clean press: key0 low at edge 0, held 10 cycles, then high -> o_press[0] pulses at edge 7; o_down[0]=1 from edge 7; o_release[0] and o_short[0] pulse once after the release debounce; o_long[0] never asserts.
REQ-033 Bounce: key1 low 2 cycles, high 1, low 2, high, then 6 cycles idle -> no pulses on any output; o_down[1] stays 0.
REQ-034 Long hold: key2 held 40 cycles -> o_press[2] pulses at edge 7; o_long[2] pulses at edge 27; on release o_release[2] pulses and o_short[2] stays 0.
REQ-035 Release bounce: key0 in HELD goes high 2 cycles then low again -> no o_release; o_down[0] stays 1; hold count continues counting.
REQ-036 Simultaneous press: keys 0 and 1 go low on the same edge -> o_press=3'b011 in a single cycle at edge 7.
REQ-037 Reset mid-hold: i_rst_n pulsed low at cycle 12 while key0 held -> all outputs 0 immediately; o_press[0] pulses again at edge 7 after deassertion; no o_release is emitted in between.
